// File: rtl/issue_queue_pkg.sv
// Types and constants shared by the issue queue, busy table and rename stage.
`ifndef PREG_INDEX_WIDTH
`define PREG_INDEX_WIDTH 6
`endif

package issue_queue_pkg;

    localparam int unsigned PREG_W     = `PREG_INDEX_WIDTH;
    localparam int unsigned UOP_W      = 64;
    localparam int unsigned DISP_WIDTH = 4;
    localparam int unsigned WB_PORTS   = 4;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] rj;
        logic [PREG_W-1:0] rk;
        logic [PREG_W-1:0] rd;
        logic              rj_rdy;
        logic              rk_rdy;
        logic [UOP_W-1:0]  uop;
    } iq_entry_t;

    // True when any valid writeback port broadcasts src this cycle.
    function automatic logic wb_match(input logic [PREG_W-1:0]                src,
                                      input logic [WB_PORTS-1:0]              wb_valid,
                                      input logic [WB_PORTS-1:0][PREG_W-1:0] wb_index);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_valid[k] && (wb_index[k] == src)) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/issue_queue_select.sv
// Lowest-index-wins one-hot selector over an issue-queue request vector.
module iq_select #(
    parameter int unsigned IQ_DEPTH = 8
) (
    input  logic [IQ_DEPTH-1:0] req,
    output logic [IQ_DEPTH-1:0] grant,
    output logic                found
);

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Single-issue collapsing issue queue: in-order packed dispatch, wb wakeup, oldest-ready select.
module issue_queue #(
    parameter int unsigned IQ_DEPTH  = 8,
    parameter int unsigned UOP_WIDTH = issue_queue_pkg::UOP_W,
    parameter int unsigned PREG_W    = issue_queue_pkg::PREG_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [3:0]                      disp_valid_vec,
    input  logic [3:0][PREG_W-1:0]          disp_rj_index_vec,
    input  logic [3:0][PREG_W-1:0]          disp_rk_index_vec,
    input  logic [3:0][PREG_W-1:0]          disp_rd_index_vec,
    input  logic [3:0]                      disp_rj_ready_vec,
    input  logic [3:0]                      disp_rk_ready_vec,
    input  logic [3:0][UOP_WIDTH-1:0]       disp_uop_vec,
    output logic                            disp_ready,
    input  logic [3:0][PREG_W-1:0]          wb_rd_index_vec,
    input  logic [3:0]                      wb_rd_valid_vec,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [PREG_W-1:0]               issue_rj_index,
    output logic [PREG_W-1:0]               issue_rk_index,
    output logic [PREG_W-1:0]               issue_rd_index,
    output logic [UOP_WIDTH-1:0]            issue_uop,
    output logic                            begin_exec_valid,
    output logic [PREG_W-1:0]               begin_exec_rd_index,
    input  logic                            flush,
    output logic [$clog2(IQ_DEPTH+1)-1:0]   free_count
);

    import issue_queue_pkg::*;

    localparam int unsigned CW = $clog2(IQ_DEPTH + 1);

    iq_entry_t               entries_q [IQ_DEPTH];
    iq_entry_t               entries_d [IQ_DEPTH];
    iq_entry_t               up_one    [IQ_DEPTH];
    iq_entry_t               sel;
    iq_entry_t               new_entry;
    logic [CW-1:0]           count_q, count_d, free_q, tail;
    logic [IQ_DEPTH-1:0]     req, grant;
    logic                    found, fire, passed;
    logic [DISP_WIDTH-1:0]   disp_ok;

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            req[i] = entries_q[i].valid & entries_q[i].rj_rdy & entries_q[i].rk_rdy;
        end
    end

    iq_select #(
        .IQ_DEPTH (IQ_DEPTH)
    ) u_select (
        .req   (req),
        .grant (grant),
        .found (found)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (grant[i]) sel = entries_q[i];
        end
    end

    // Readiness looks only at registered occupancy, never at same-cycle issue.
    assign disp_ready          = (free_q >= CW'(DISP_WIDTH)) && !flush;
    assign issue_valid         = found && !flush;
    assign fire                = issue_valid && issue_ready;
    assign issue_rj_index      = sel.rj;
    assign issue_rk_index      = sel.rk;
    assign issue_rd_index      = sel.rd;
    assign issue_uop           = sel.uop;
    assign begin_exec_valid    = fire;
    assign begin_exec_rd_index = sel.rd;
    assign free_count          = free_q;

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) up_one[i] = '0;
        for (int i = 0; i < IQ_DEPTH - 1; i++) up_one[i] = entries_q[i + 1];
    end

    always_comb begin
        passed    = 1'b0;
        new_entry = '0;
        // Collapse over the fired slot, then wake the post-shift contents.
        for (int i = 0; i < IQ_DEPTH; i++) begin
            passed = passed | grant[i];
            entries_d[i] = (fire && passed) ? up_one[i] : entries_q[i];
            if (entries_d[i].valid) begin
                entries_d[i].rj_rdy = entries_d[i].rj_rdy |
                    wb_match(entries_d[i].rj, wb_rd_valid_vec, wb_rd_index_vec);
                entries_d[i].rk_rdy = entries_d[i].rk_rdy |
                    wb_match(entries_d[i].rk, wb_rd_valid_vec, wb_rd_index_vec);
            end
        end

        disp_ok = disp_valid_vec & {DISP_WIDTH{disp_ready}};
        tail    = count_q - CW'(fire);
        for (int l = 0; l < DISP_WIDTH; l++) begin
            if (disp_ok[l]) begin
                new_entry.valid  = 1'b1;
                new_entry.rj     = disp_rj_index_vec[l];
                new_entry.rk     = disp_rk_index_vec[l];
                new_entry.rd     = disp_rd_index_vec[l];
                new_entry.uop    = disp_uop_vec[l];
                new_entry.rj_rdy = disp_rj_ready_vec[l] | (disp_rj_index_vec[l] == '0) |
                    wb_match(disp_rj_index_vec[l], wb_rd_valid_vec, wb_rd_index_vec);
                new_entry.rk_rdy = disp_rk_ready_vec[l] | (disp_rk_index_vec[l] == '0) |
                    wb_match(disp_rk_index_vec[l], wb_rd_valid_vec, wb_rd_index_vec);
                for (int s = 0; s < IQ_DEPTH; s++) begin
                    if (tail == CW'(s)) entries_d[s] = new_entry;
                end
                tail = tail + CW'(1);
            end
        end
        count_d = tail;

        if (flush) begin
            for (int i = 0; i < IQ_DEPTH; i++) entries_d[i] = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IQ_DEPTH; i++) entries_q[i] <= '0;
            count_q <= '0;
            free_q  <= CW'(IQ_DEPTH);
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            free_q    <= CW'(IQ_DEPTH) - count_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for the collapsing issue queue.
module tb_issue_queue;

    localparam int unsigned PW = issue_queue_pkg::PREG_W;
    localparam int unsigned UW = issue_queue_pkg::UOP_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            disp_valid_vec;
    logic [3:0][PW-1:0]    disp_rj_index_vec, disp_rk_index_vec, disp_rd_index_vec;
    logic [3:0]            disp_rj_ready_vec, disp_rk_ready_vec;
    logic [3:0][UW-1:0]    disp_uop_vec;
    logic                  disp_ready;
    logic [3:0][PW-1:0]    wb_rd_index_vec;
    logic [3:0]            wb_rd_valid_vec;
    logic                  issue_valid, issue_ready;
    logic [PW-1:0]         issue_rj_index, issue_rk_index, issue_rd_index;
    logic [UW-1:0]         issue_uop;
    logic                  begin_exec_valid;
    logic [PW-1:0]         begin_exec_rd_index;
    logic                  flush;
    logic [3:0]            free_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    issue_queue dut (
        .clk                 (clk),
        .rst                 (rst),
        .disp_valid_vec      (disp_valid_vec),
        .disp_rj_index_vec   (disp_rj_index_vec),
        .disp_rk_index_vec   (disp_rk_index_vec),
        .disp_rd_index_vec   (disp_rd_index_vec),
        .disp_rj_ready_vec   (disp_rj_ready_vec),
        .disp_rk_ready_vec   (disp_rk_ready_vec),
        .disp_uop_vec        (disp_uop_vec),
        .disp_ready          (disp_ready),
        .wb_rd_index_vec     (wb_rd_index_vec),
        .wb_rd_valid_vec     (wb_rd_valid_vec),
        .issue_valid         (issue_valid),
        .issue_ready         (issue_ready),
        .issue_rj_index      (issue_rj_index),
        .issue_rk_index      (issue_rk_index),
        .issue_rd_index      (issue_rd_index),
        .issue_uop           (issue_uop),
        .begin_exec_valid    (begin_exec_valid),
        .begin_exec_rd_index (begin_exec_rd_index),
        .flush               (flush),
        .free_count          (free_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_disp();
        disp_valid_vec    = '0;
        disp_rj_index_vec = '0;
        disp_rk_index_vec = '0;
        disp_rd_index_vec = '0;
        disp_rj_ready_vec = '0;
        disp_rk_ready_vec = '0;
        disp_uop_vec      = '0;
    endtask

    task automatic clear_all();
        clear_disp();
        wb_rd_index_vec = '0;
        wb_rd_valid_vec = '0;
        issue_ready     = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic set_lane(input int l, input int rj, input logic rjr, input int rk,
                            input logic rkr, input int rd, input int uop);
        disp_valid_vec[l]    = 1'b1;
        disp_rj_index_vec[l] = PW'(rj);
        disp_rj_ready_vec[l] = rjr;
        disp_rk_index_vec[l] = PW'(rk);
        disp_rk_ready_vec[l] = rkr;
        disp_rd_index_vec[l] = PW'(rd);
        disp_uop_vec[l]      = UW'(uop);
    endtask

    task automatic test_reset();
        clear_all();
        rst = 1'b1;
        #2;
        total++; if (free_count !== 4'd8) begin bad++; $display("FAIL reset_free got=%0d want=8", free_count); end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL reset_disp_ready got=%b want=1", disp_ready); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got=%b want=0", issue_valid); end
        total++; if (begin_exec_valid !== 1'b0) begin bad++; $display("FAIL reset_begin_exec got=%b want=0", begin_exec_valid); end
        total++; if (issue_uop !== '0 || issue_rd_index !== '0 || issue_rj_index !== '0)
            begin bad++; $display("FAIL reset_fields got=%0d/%0d/%0d want=0/0/0", issue_uop, issue_rd_index, issue_rj_index); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_in_order();
        clear_all();
        for (int l = 0; l < 4; l++) set_lane(l, 2 * l + 1, 1'b1, 2 * l + 2, 1'b1, 20 + l, 100 + l);
        issue_ready = 1'b1;
        #1;
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL inorder_disp_ready got=%b want=1", disp_ready); end
        tick();
        clear_disp();
        #1;
        for (int k = 0; k < 4; k++) begin
            total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL inorder_valid%0d got=%b want=1", k, issue_valid); end
            total++; if (issue_uop !== UW'(100 + k)) begin bad++; $display("FAIL inorder_uop%0d got=%0d want=%0d", k, issue_uop, 100 + k); end
            total++; if (issue_rj_index !== PW'(2 * k + 1)) begin bad++; $display("FAIL inorder_rj%0d got=%0d want=%0d", k, issue_rj_index, 2 * k + 1); end
            total++; if (begin_exec_valid !== 1'b1 || begin_exec_rd_index !== PW'(20 + k))
                begin bad++; $display("FAIL inorder_bexec%0d got=%b/%0d want=1/%0d", k, begin_exec_valid, begin_exec_rd_index, 20 + k); end
            total++; if (free_count !== 4'(4 + k)) begin bad++; $display("FAIL inorder_free%0d got=%0d want=%0d", k, free_count, 4 + k); end
            tick();
        end
        total++; if (free_count !== 4'd8) begin bad++; $display("FAIL inorder_free_end got=%0d want=8", free_count); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL inorder_valid_end got=%b want=0", issue_valid); end
    endtask

    task automatic test_wakeup();
        clear_all();
        set_lane(0, 10, 1'b0, 11, 1'b1, 30, 200);
        issue_ready = 1'b1;
        tick();
        clear_disp();
        wb_rd_valid_vec    = 4'b0100;
        wb_rd_index_vec[2] = PW'(10);
        #1;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wakeup_same_cycle got=%b want=0", issue_valid); end
        tick();
        wb_rd_valid_vec = '0;
        wb_rd_index_vec = '0;
        #1;
        total++; if (issue_valid !== 1'b1 || issue_uop !== UW'(200))
            begin bad++; $display("FAIL wakeup_next_cycle got=%b/%0d want=1/200", issue_valid, issue_uop); end
        tick();
        total++; if (free_count !== 4'd8) begin bad++; $display("FAIL wakeup_free got=%0d want=8", free_count); end
    endtask

    task automatic test_disp_wb();
        clear_all();
        set_lane(0, 12, 1'b0, 13, 1'b1, 31, 300);
        wb_rd_valid_vec    = 4'b0001;
        wb_rd_index_vec[0] = PW'(12);
        issue_ready        = 1'b1;
        #1;
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL dispwb_empty got=%b want=0", issue_valid); end
        tick();
        clear_all();
        issue_ready = 1'b1;
        #1;
        total++; if (issue_valid !== 1'b1 || issue_uop !== UW'(300))
            begin bad++; $display("FAIL dispwb_issue got=%b/%0d want=1/300", issue_valid, issue_uop); end
        tick();
    endtask

    task automatic test_full_collapse();
        clear_all();
        for (int l = 0; l < 4; l++) set_lane(l, 40 + l, 1'b0, 2, 1'b1, 50 + l, 400 + l);
        tick();
        clear_disp();
        for (int l = 0; l < 4; l++) set_lane(l, 44 + l, 1'b0, 2, 1'b1, 54 + l, 404 + l);
        tick();
        clear_disp();
        #1;
        total++; if (disp_ready !== 1'b0 || free_count !== 4'd0)
            begin bad++; $display("FAIL full_state got=%b/%0d want=0/0", disp_ready, free_count); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL full_no_issue got=%b want=0", issue_valid); end
        wb_rd_valid_vec    = 4'b1000;
        wb_rd_index_vec[3] = PW'(43);
        tick();
        wb_rd_valid_vec = '0;
        issue_ready     = 1'b1;
        #1;
        total++; if (issue_valid !== 1'b1 || issue_uop !== UW'(403))
            begin bad++; $display("FAIL full_pick3 got=%b/%0d want=1/403", issue_valid, issue_uop); end
        tick();
        issue_ready = 1'b0;
        #1;
        total++; if (free_count !== 4'd1 || disp_ready !== 1'b0)
            begin bad++; $display("FAIL full_after_issue got=%0d/%b want=1/0", free_count, disp_ready); end
        wb_rd_valid_vec = 4'b1111;
        for (int k = 0; k < 4; k++) wb_rd_index_vec[k] = PW'(47 - k);
        tick();
        wb_rd_valid_vec = '0;
        issue_ready     = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++; if (issue_uop !== UW'(404 + k) || free_count !== 4'(1 + k))
                begin bad++; $display("FAIL full_shift%0d got=%0d/%0d want=%0d/%0d", k, issue_uop, free_count, 404 + k, 1 + k); end
            tick();
        end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL full_old_waiting got=%b want=0", issue_valid); end
        wb_rd_valid_vec = 4'b0111;
        for (int k = 0; k < 3; k++) wb_rd_index_vec[k] = PW'(40 + k);
        tick();
        wb_rd_valid_vec = '0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (issue_uop !== UW'(400 + k))
                begin bad++; $display("FAIL full_old%0d got=%0d want=%0d", k, issue_uop, 400 + k); end
            tick();
        end
        total++; if (free_count !== 4'd8) begin bad++; $display("FAIL full_drained got=%0d want=8", free_count); end
    endtask

    task automatic test_issue_and_dispatch();
        clear_all();
        set_lane(0, 1, 1'b1, 2, 1'b1, 5, 500);
        for (int l = 1; l < 4; l++) set_lane(l, 29 + l, 1'b0, 2, 1'b1, 5 + l, 500 + l);
        tick();
        clear_disp();
        issue_ready = 1'b1;
        set_lane(0, 33, 1'b0, 2, 1'b1, 9, 510);
        set_lane(2, 34, 1'b0, 2, 1'b1, 10, 512);
        #1;
        total++; if (issue_valid !== 1'b1 || issue_uop !== UW'(500) || disp_ready !== 1'b1)
            begin bad++; $display("FAIL both_cycle got=%b/%0d/%b want=1/500/1", issue_valid, issue_uop, disp_ready); end
        tick();
        clear_all();
        #1;
        total++; if (free_count !== 4'd3 || disp_ready !== 1'b0)
            begin bad++; $display("FAIL both_count got=%0d/%b want=3/0", free_count, disp_ready); end
        wb_rd_valid_vec    = 4'b0011;
        wb_rd_index_vec[0] = PW'(33);
        wb_rd_index_vec[1] = PW'(34);
        issue_ready        = 1'b1;
        tick();
        wb_rd_valid_vec = '0;
        #1;
        total++; if (issue_uop !== UW'(510)) begin bad++; $display("FAIL both_slot3 got=%0d want=510", issue_uop); end
        tick();
        total++; if (issue_uop !== UW'(512)) begin bad++; $display("FAIL both_slot4 got=%0d want=512", issue_uop); end
        tick();
        wb_rd_valid_vec = 4'b0111;
        for (int k = 0; k < 3; k++) wb_rd_index_vec[k] = PW'(30 + k);
        tick();
        wb_rd_valid_vec = '0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (issue_uop !== UW'(501 + k))
                begin bad++; $display("FAIL both_old%0d got=%0d want=%0d", k, issue_uop, 501 + k); end
            tick();
        end
        total++; if (free_count !== 4'd8) begin bad++; $display("FAIL both_drained got=%0d want=8", free_count); end
    endtask

    task automatic test_flush();
        clear_all();
        set_lane(0, 1, 1'b1, 2, 1'b1, 5, 600);
        for (int l = 1; l < 4; l++) set_lane(l, 34 + l, 1'b0, 2, 1'b1, 5, 600 + l);
        tick();
        clear_disp();
        set_lane(0, 38, 1'b0, 2, 1'b1, 5, 604);
        set_lane(1, 39, 1'b0, 2, 1'b1, 5, 605);
        tick();
        clear_disp();
        #1;
        total++; if (free_count !== 4'd2 || issue_valid !== 1'b1)
            begin bad++; $display("FAIL flush_pre got=%0d/%b want=2/1", free_count, issue_valid); end
        flush       = 1'b1;
        issue_ready = 1'b1;
        for (int l = 0; l < 4; l++) set_lane(l, 1, 1'b1, 2, 1'b1, 5, 690 + l);
        #1;
        total++; if (issue_valid !== 1'b0 || begin_exec_valid !== 1'b0 || disp_ready !== 1'b0)
            begin bad++; $display("FAIL flush_cycle got=%b/%b/%b want=0/0/0", issue_valid, begin_exec_valid, disp_ready); end
        tick();
        clear_all();
        #1;
        total++; if (free_count !== 4'd8 || issue_valid !== 1'b0 || disp_ready !== 1'b1)
            begin bad++; $display("FAIL flush_after got=%0d/%b/%b want=8/0/1", free_count, issue_valid, disp_ready); end
    endtask

    task automatic test_async_reset();
        clear_all();
        set_lane(0, 1, 1'b1, 2, 1'b1, 9, 700);
        tick();
        clear_disp();
        #1;
        total++; if (issue_valid !== 1'b1 || issue_uop !== UW'(700))
            begin bad++; $display("FAIL areset_pre got=%b/%0d want=1/700", issue_valid, issue_uop); end
        rst = 1'b1;
        #1;
        total++; if (issue_valid !== 1'b0 || free_count !== 4'd8 || issue_uop !== '0 || begin_exec_rd_index !== '0)
            begin bad++; $display("FAIL areset_now got=%b/%0d/%0d/%0d want=0/8/0/0", issue_valid, free_count, issue_uop, begin_exec_rd_index); end
        #1;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_in_order();
        test_wakeup();
        test_disp_wb();
        test_full_collapse();
        test_issue_and_dispatch();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
